// File: rtl/bitserial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package bitserial_add_pkg;

   // Default operand width in bits.
   localparam int DEFAULT_WIDTH = 8;

   // Controller states: waiting for operands, shifting bits, holding the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : bitserial_add_pkg

// File: rtl/bitserial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
interface bitserial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   // Producer/consumer side: offers operands, takes results.
   modport master (
      output start_valid, a, b, cin, res_ready,
      input  start_ready, res_valid, sum, cout, busy
   );

   // Adder side: takes operands, offers results.
   modport slave (
      input  start_valid, a, b, cin, res_ready,
      output start_ready, res_valid, sum, cout, busy
   );
endinterface : bitserial_add_ctrl_if

// File: rtl/bitserial_add_ctrl_halfadder.sv
// One-bit half adder; two of these plus an OR form the full-adder slice.
module halfadder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule : halfadder

// File: rtl/bitserial_add_ctrl.sv
// Bit-serial adder: accepts a/b/cin, adds one bit per cycle LSB first,
// then presents {cout,sum} until the consumer takes it.
module bitserial_add_ctrl
   import bitserial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bitserial_add_ctrl_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic             cout_r;
   logic             start_ready_r;
   logic             res_valid_r;
   logic             busy_r;

   logic             ha0_sum_s;
   logic             ha0_carry_s;
   logic             ha1_sum_s;
   logic             ha1_carry_s;
   logic             slice_carry_s;

   // Full-adder slice on the current LSBs and the running carry.
   halfadder u_ha0 (
      .x (a_sh_r[0]),
      .y (b_sh_r[0]),
      .s (ha0_sum_s),
      .c (ha0_carry_s)
   );

   halfadder u_ha1 (
      .x (ha0_sum_s),
      .y (carry_r),
      .s (ha1_sum_s),
      .c (ha1_carry_s)
   );

   assign slice_carry_s = ha0_carry_s | ha1_carry_s;

   // Controller FSM with datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         a_sh_r        <= '0;
         b_sh_r        <= '0;
         sum_r         <= '0;
         cnt_r         <= '0;
         carry_r       <= 1'b0;
         cout_r        <= 1'b0;
         start_ready_r <= 1'b1;
         res_valid_r   <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               // sum/cout keep the previous result until a new accept.
               if (bus.start_valid) begin
                  a_sh_r        <= bus.a;
                  b_sh_r        <= bus.b;
                  carry_r       <= bus.cin;
                  cnt_r         <= '0;
                  state_r       <= RUN;
                  start_ready_r <= 1'b0;
                  busy_r        <= 1'b1;
               end
            end
            RUN: begin
               a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
               sum_r   <= {ha1_sum_s, sum_r[WIDTH-1:1]};
               carry_r <= slice_carry_s;
               if (cnt_r == LAST_BIT) begin
                  cout_r      <= slice_carry_s;
                  state_r     <= DONE;
                  res_valid_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            DONE: begin
               // Handshake edge only returns to IDLE; accepting waits a cycle.
               if (bus.res_ready) begin
                  state_r       <= IDLE;
                  res_valid_r   <= 1'b0;
                  busy_r        <= 1'b0;
                  start_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r       <= IDLE;
               res_valid_r   <= 1'b0;
               busy_r        <= 1'b0;
               start_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.start_ready = start_ready_r;
   assign bus.res_valid   = res_valid_r;
   assign bus.busy        = busy_r;
   assign bus.sum         = sum_r;
   assign bus.cout        = cout_r;

endmodule : bitserial_add_ctrl

// File: tb/tb_bitserial_add_ctrl.sv
// Self-checking bench: directed corner cases plus a random regression
// against an arithmetic reference ({cout,sum} = a + b + cin).
module tb_bitserial_add_ctrl;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   bitserial_add_ctrl_if #(.WIDTH(W)) bus ();

   bitserial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One transaction: offer operands at a negedge while idle, scramble the
   // inputs while busy, measure latency, hold res_ready low for 'hold' cycles.
   task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input int hold);
      logic [W:0] exp;
      int         lat;
      exp = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
      lat = 0;
      while (!bus.start_ready && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check_val("idle_ready", bus.start_ready, 1);
      bus.a           = ta;
      bus.b           = tb_v;
      bus.cin         = tc;
      bus.start_valid = 1'b1;
      bus.res_ready   = (hold == 0);
      @(negedge clk);
      check_val("run_busy", bus.busy, 1);
      check_val("run_ready", bus.start_ready, 0);
      lat = 0;
      while (!bus.res_valid && lat < 50) begin
         bus.a   = W'($urandom);
         bus.b   = W'($urandom);
         bus.cin = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      check_val("latency", lat, W);
      check_val("sum", bus.sum, exp[W-1:0]);
      check_val("cout", bus.cout, exp[W]);
      for (int i = 0; i < hold; i++) begin
         bus.a = W'($urandom);
         @(negedge clk);
         check_val("hold_valid", bus.res_valid, 1);
         check_val("hold_sum", bus.sum, exp[W-1:0]);
         check_val("hold_cout", bus.cout, exp[W]);
         check_val("hold_ready", bus.start_ready, 0);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      check_val("post_valid", bus.res_valid, 0);
      check_val("post_ready", bus.start_ready, 1);
      check_val("post_busy", bus.busy, 0);
      check_val("idle_sum", bus.sum, exp[W-1:0]);
      check_val("idle_cout", bus.cout, exp[W]);
   endtask

   task automatic reset_mid_run();
      int seen;
      @(negedge clk);
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b1;
      bus.start_valid = 1'b1;
      bus.res_ready   = 1'b1;
      @(posedge clk);   // accept edge
      @(negedge clk);
      bus.start_valid = 1'b0;
      @(posedge clk);   // RUN cycle 1 edge
      @(posedge clk);   // RUN cycle 2 edge; now in 3rd RUN cycle
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_ready", bus.start_ready, 1);
      check_val("rst_valid", bus.res_valid, 0);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_sum", bus.sum, 0);
      check_val("rst_cout", bus.cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.res_valid) seen++;
      end
      check_val("no_result_after_rst", seen, 0);
      check_val("rst_idle_ready", bus.start_ready, 1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.start_valid = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.res_ready = 1'b0;
      #12;
      check_val("reset_ready", bus.start_ready, 1);
      check_val("reset_valid", bus.res_valid, 0);
      check_val("reset_busy", bus.busy, 0);
      check_val("reset_sum", bus.sum, 0);
      check_val("reset_cout", bus.cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_txn(8'h5A, 8'h3C, 1'b0, 0);
      do_txn(8'hFF, 8'h00, 1'b1, 0);
      do_txn(8'hFF, 8'hFF, 1'b1, 0);
      do_txn(8'h81, 8'h7F, 1'b0, 5);
      // Back-to-back with start_valid held high and operands churning.
      do_txn(8'h01, 8'h02, 1'b0, 0);
      do_txn(8'hC0, 8'h40, 1'b1, 1);

      reset_mid_run();

      for (int n = 0; n < 1000; n++) begin
         do_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule : tb_bitserial_add_ctrl

// File: doc/bitserial_add_ctrl.md
BITSERIAL_ADD_CTRL -- requirements
Module: bitserial_add_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter SHALL be: WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-003 Port SHALL be: clk  input  1  rising-edge clock.
REQ-004 Port SHALL be: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port SHALL be: start_valid  input  1  operands a/b/cin valid.
REQ-006 Port SHALL be: start_ready  output  1  block can accept operands.
REQ-007 Port SHALL be: a  input  WIDTH  addend A.
REQ-008 Port SHALL be: b  input  WIDTH  addend B.
REQ-009 Port SHALL be: cin  input  1  carry-in.
REQ-010 Port SHALL be: res_valid  output  1  sum/cout valid.
REQ-011 Port SHALL be: res_ready  input  1  consumer accepts result.
REQ-012 Port SHALL be: sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-013 Port SHALL be: cout  output  1  carry out of bit WIDTH-1.
REQ-014 Port SHALL be: busy  output  1  high in RUN or DONE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 start_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in DONE; busy SHALL equal (state != IDLE).
REQ-017 Accept: when start_valid & start_ready at an edge, the block SHALL latch a, b and cin into shift and carry registers, clear the bit counter and go to RUN.
REQ-018 RUN: each cycle SHALL process one bit, LSB first, through one full-adder slice built from two halfadder instances and an OR of their carries.
REQ-019 The slice output bit SHALL be shifted into sum from the MSB side; the carry register SHALL be updated with the slice carry.
REQ-020 RUN SHALL last exactly WIDTH cycles; the counter SHALL be $clog2(WIDTH) bits wide and compared against WIDTH-1 to terminate.
REQ-021 Latency: res_valid SHALL rise exactly WIDTH clock edges after the accept edge.
REQ-022 DONE: sum and cout SHALL be held stable while res_valid=1 and res_ready=0.
REQ-023 Edge with res_valid & res_ready SHALL return the FSM to IDLE; no new operands SHALL be accepted on that same edge.
REQ-024 a, b, cin and start_valid changes during RUN or DONE SHALL be ignored.
REQ-025 Full overflow (all-ones + all-ones + cin=1) SHALL give sum = all-ones and cout=1; the sum SHALL wrap modulo 2^WIDTH.
REQ-026 sum and cout SHALL keep the last result in IDLE until the next accept.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force state=IDLE, counter=0, sum=0, cout=0, carry=0, operand registers=0, res_valid=0, busy=0 and start_ready=1.
REQ-028 Reset in RUN or DONE SHALL abort the operation with no result delivered; release is synchronous to the next clk edge.

Structure
REQ-029 Package bitserial_add_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-030 The datapath slice SHALL be two instances of the existing halfadder sub-module; no other sub-module.

Verification (WIDTH=8)
REQ-031 a=0x5A, b=0x3C, cin=0, res_ready=1 -> sum=0x96, cout=0, res_valid high for 1 cycle, 8 edges after accept.
REQ-032 a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 res_ready held 0 for 5 cycles in DONE -> res_valid, sum and cout stable, start_ready=0; the result is taken on the first res_ready=1 edge.
REQ-034 rst_n pulsed low in the 3rd RUN cycle -> all outputs at reset values asynchronously, start_ready=1, no res_valid afterwards.
REQ-035 start_valid held 1 with changing a/b across two transactions -> only operands at the accept edges are used; exactly one IDLE cycle separates the transactions.
REQ-036 Random a/b/cin regression (1000 transactions) -> every result matches {cout,sum} = a+b+cin.
